branch_resolve_ctrl: RTL and testbench
======================================

Name: branch_resolve_ctrl

Overview:
Branch resolution controller in the EX stage. It accepts one control-flow op at a time from issue and sequences the shared branch comparator. It compares the comparator outcome against the fetch prediction. On a mismatch it drives a flush pulse and a held redirect handshake to fetch, and on every resolution it reports outcome and statistics for predictor update and performance counters.

Parameters:
RESET_PC, 32'h0000_0000, reset value of res_pc_o and redirect_pc_o
CNT_W, 32, width of statistics counters

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
ex_valid_i  in  1  op offered by issue
ex_ready_o  out  1  controller can accept op
ex_pc_i  in  32  PC of op
ex_cmp_op_i  in  5  [4:3] class (00 none, 01 conditional, 10 jump, 11 none), [2:0] func
ex_num1_i  in  32  comparator operand 1
ex_num2_i  in  32  comparator operand 2
ex_target_i  in  32  computed taken target
ex_pred_taken_i  in  1  fetch predicted taken
ex_pred_target_i  in  32  fetch predicted target
cmp_op_o  out  5  to shared comparator
cmp_num1_o  out  32  to shared comparator
cmp_num2_o  out  32  to shared comparator
cmp_taken_i  in  1  comparator result, combinational from cmp_*_o
flush_i  in  1  higher-priority pipeline flush (trap)
flush_o  out  1  one-cycle younger-instruction flush
redirect_valid_o  out  1  redirect request to fetch
redirect_ready_i  in  1  fetch accepts redirect
redirect_pc_o  out  32  correct next PC
res_valid_o  out  1  one-cycle resolution pulse
res_taken_o  out  1  resolved direction
res_pc_o  out  32  PC of resolved op
misalign_o  out  1  one-cycle misaligned-taken-target pulse
branch_cnt_o  out  CNT_W  resolved class 01/10 ops
mispred_cnt_o  out  CNT_W  mispredictions

Behaviour:
- Reset (async, rst_n_i low): state IDLE; ex_ready_o=1; flush_o, redirect_valid_o, res_valid_o, res_taken_o and misalign_o are 0; redirect_pc_o and res_pc_o are RESET_PC; counters 0; cmp_*_o are 0.
- States: IDLE, EVAL, REDIRECT.
- IDLE:
  - ex_ready_o = ~flush_i.
  - Handshake fires when ex_valid_i & ex_ready_o. All ex_* inputs are captured in registers and the next state is EVAL.
- EVAL (exactly 1 cycle):
  - cmp_*_o are driven from the registers. cmp_*_o hold their last values outside EVAL.
  - ex_ready_o=0.
  - taken = cmp_taken_i.
  - next_pc = taken ? target : pc+4 (mod 2^32).
  - mispred = (taken != pred_taken) | (taken & (target != pred_target)).
  - Classes 00/11 are forced not-taken; mispred is set if pred_taken=1.
  - misalign = taken & (target[1:0] != 0).
- Edge leaving EVAL, all outputs registered and visible in the next cycle:
  - res_valid_o=1 and res_taken_o/res_pc_o are updated.
  - branch_cnt_o increments for class 01/10.
  - If misalign: misalign_o=1; no flush, no redirect, mispred_cnt_o unchanged; next state IDLE.
  - Else if mispred: flush_o=1 (one cycle), redirect_valid_o=1, redirect_pc_o=next_pc, mispred_cnt_o increments; next state REDIRECT.
  - Else: next state IDLE.
- REDIRECT:
  - ex_ready_o=0.
  - redirect_valid_o and redirect_pc_o are held stable until redirect_ready_i=1. On that edge redirect_valid_o drops and the next state is IDLE.
  - Ready may already be high in the first REDIRECT cycle, giving a 1-cycle handshake.
- Latency and throughput:
  - Accept at the edge ending cycle N gives res_valid_o in cycle N+2.
  - Peak throughput is 1 op per 2 cycles. A new op may be accepted in the same cycle res_valid_o is high (no-mispredict case).
- flush_i, synchronous, highest priority:
  - Any state goes to IDLE next cycle.
  - redirect_valid_o is cleared and any pending res_valid_o, flush_o and misalign_o are suppressed.
  - Counters do not update for the aborted op.
  - flush_i in IDLE blocks acceptance.
- Counters wrap at 2^CNT_W, with no saturation.
- Reset asserted mid-operation: immediate return to reset values; no partial outputs.

Test Plan:
- BEQ, num1=num2=5, pred_taken=0, target=0x100, pc=0x40 -> cycle N+2: res_valid_o=1, res_taken_o=1, flush_o=1, redirect_valid_o=1, redirect_pc_o=0x100, mispred_cnt_o=1, branch_cnt_o=1.
- BLTU, num1=0xFFFF_FFFF, num2=1, pred_taken=0, pc=0x80 -> not taken, no flush/redirect, res_valid_o=1, redirect_pc_o unchanged; back-to-back op accepted in cycle N+2.
- Jump (class 10), pred_taken=1, pred_target=0x200, target=0x204 -> mispred, redirect_pc_o=0x204; redirect_ready_i held low 3 cycles -> redirect_valid_o and redirect_pc_o stable, ex_ready_o=0 throughout; ready high -> IDLE next cycle.
- Class 00 op, pred_taken=1, pc=0xFFFF_FFFC -> mispred, redirect_pc_o=0x0000_0000 (wrap), branch_cnt_o unchanged, mispred_cnt_o +1.
- Taken BNE, target=0x102 -> misalign_o=1 one cycle, flush_o=0, redirect_valid_o=0, mispred_cnt_o unchanged.
- flush_i asserted in EVAL, and separately in REDIRECT -> IDLE next cycle, no res_valid_o, redirect_valid_o drops, counters unchanged; rst_n_i low mid-REDIRECT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// EX-stage branch resolution controller. Takes one control-flow op at a time
// from issue and drives the shared branch comparator for one cycle. It then
// checks the comparator result against the fetch prediction. A misprediction
// raises a one-cycle younger-op flush and a redirect request to fetch. The
// redirect request is held until fetch accepts it. Every resolution produces
// a result pulse plus branch/mispredict statistics.
//
// Ports
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   ex_*                    op handshake and operands from issue
//   cmp_*_o / cmp_taken_i   shared comparator; its result is combinational
//   flush_i                 higher-priority pipeline flush (trap)
//   flush_o                 one-cycle younger-instruction flush
//   redirect_*              redirect handshake to fetch
//   res_*_o, misalign_o     resolution pulse and outcome
//   branch_cnt_o            count of resolved conditional/jump ops
//   mispred_cnt_o           count of mispredictions
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | ready for a new op (unless flush_i is high)
// ST_EVAL     | comparator driven from captured op; outcome computed
// ST_REDIRECT | redirect to fetch pending, waiting on redirect_ready_i
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             ex_valid_i,
    output logic             ex_ready_o,
    input  logic [31:0]      ex_pc_i,
    input  logic [4:0]       ex_cmp_op_i,
    input  logic [31:0]      ex_num1_i,
    input  logic [31:0]      ex_num2_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_target_i,
    output logic [4:0]       cmp_op_o,
    output logic [31:0]      cmp_num1_o,
    output logic [31:0]      cmp_num2_o,
    input  logic             cmp_taken_i,
    input  logic             flush_i,
    output logic             flush_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [31:0]      redirect_pc_o,
    output logic             res_valid_o,
    output logic             res_taken_o,
    output logic [31:0]      res_pc_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EVAL     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t state_q, state_d;

    // captured op; op/num registers double as the held comparator inputs
    logic [31:0] pc_q, pc_d;
    logic [4:0]  op_q, op_d;
    logic [31:0] num1_q, num1_d;
    logic [31:0] num2_q, num2_d;
    logic [31:0] target_q, target_d;
    logic        pred_taken_q, pred_taken_d;
    logic [31:0] pred_target_q, pred_target_d;

    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic [31:0]      res_pc_q, res_pc_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic        accept;
    logic        is_branch;
    logic        taken;
    logic        mispred;
    logic        misalign;
    logic [31:0] next_pc;

    assign accept = (state_q == ST_IDLE) & ex_valid_i & ~flush_i;

    // classes 00/11 carry no control flow: comparator result is ignored
    assign is_branch = (op_q[4:3] == 2'b01) | (op_q[4:3] == 2'b10);
    assign taken     = is_branch & cmp_taken_i;
    assign next_pc   = taken ? target_q : (pc_q + 32'd4);
    assign mispred   = (taken != pred_taken_q) |
                       (taken & (target_q != pred_target_q));
    assign misalign  = taken & (target_q[1:0] != 2'b00);

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        op_d             = op_q;
        num1_d           = num1_q;
        num2_d           = num2_q;
        target_d         = target_q;
        pred_taken_d     = pred_taken_q;
        pred_target_d    = pred_target_q;
        flush_d          = 1'b0;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        res_valid_d      = 1'b0;
        res_taken_d      = res_taken_q;
        res_pc_d         = res_pc_q;
        misalign_d       = 1'b0;
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    pc_d          = ex_pc_i;
                    op_d          = ex_cmp_op_i;
                    num1_d        = ex_num1_i;
                    num2_d        = ex_num2_i;
                    target_d      = ex_target_i;
                    pred_taken_d  = ex_pred_taken_i;
                    pred_target_d = ex_pred_target_i;
                    state_d       = ST_EVAL;
                end
            end
            ST_EVAL: begin
                res_valid_d = 1'b1;
                res_taken_d = taken;
                res_pc_d    = pc_q;
                if (is_branch) begin
                    branch_cnt_d = branch_cnt_q + CNT_W'(1);
                end
                // a misaligned taken target is reported as an exception,
                // not as a misprediction
                if (misalign) begin
                    misalign_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (mispred) begin
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = next_pc;
                    mispred_cnt_d    = mispred_cnt_q + CNT_W'(1);
                    state_d          = ST_REDIRECT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) begin
                    redirect_valid_d = 1'b0;
                    state_d          = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // trap flush aborts whatever is in flight without any side effects
        if (flush_i) begin
            state_d          = ST_IDLE;
            flush_d          = 1'b0;
            redirect_valid_d = 1'b0;
            redirect_pc_d    = redirect_pc_q;
            res_valid_d      = 1'b0;
            res_taken_d      = res_taken_q;
            res_pc_d         = res_pc_q;
            misalign_d       = 1'b0;
            branch_cnt_d     = branch_cnt_q;
            mispred_cnt_d    = mispred_cnt_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            pc_q             <= 32'd0;
            op_q             <= 5'd0;
            num1_q           <= 32'd0;
            num2_q           <= 32'd0;
            target_q         <= 32'd0;
            pred_taken_q     <= 1'b0;
            pred_target_q    <= 32'd0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= RESET_PC;
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_pc_q         <= RESET_PC;
            misalign_q       <= 1'b0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            op_q             <= op_d;
            num1_q           <= num1_d;
            num2_q           <= num2_d;
            target_q         <= target_d;
            pred_taken_q     <= pred_taken_d;
            pred_target_q    <= pred_target_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_pc_q         <= res_pc_d;
            misalign_q       <= misalign_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign ex_ready_o       = (state_q == ST_IDLE) & ~flush_i;
    assign cmp_op_o         = op_q;
    assign cmp_num1_o       = num1_q;
    assign cmp_num2_o       = num2_q;
    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign res_valid_o      = res_valid_q;
    assign res_taken_o      = res_taken_q;
    assign res_pc_o         = res_pc_q;
    assign misalign_o       = misalign_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign mispred_cnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for branch_resolve_ctrl. A driver issues ops and pushes the
// expected resolution into a queue. A monitor pops the queue and compares
// on every res_valid_o. A fetch responder process models redirect back-pressure.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ex_valid_i;
    logic        ex_ready_o;
    logic [31:0] ex_pc_i;
    logic [4:0]  ex_cmp_op_i;
    logic [31:0] ex_num1_i;
    logic [31:0] ex_num2_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic [31:0] ex_pred_target_i;
    logic [4:0]  cmp_op_o;
    logic [31:0] cmp_num1_o;
    logic [31:0] cmp_num2_o;
    logic        cmp_taken_i;
    logic        flush_i;
    logic        flush_o;
    logic        redirect_valid_o;
    logic        redirect_ready_i;
    logic [31:0] redirect_pc_o;
    logic        res_valid_o;
    logic        res_taken_o;
    logic [31:0] res_pc_o;
    logic        misalign_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispred_cnt_o;

    branch_resolve_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .ex_valid_i       (ex_valid_i),
        .ex_ready_o       (ex_ready_o),
        .ex_pc_i          (ex_pc_i),
        .ex_cmp_op_i      (ex_cmp_op_i),
        .ex_num1_i        (ex_num1_i),
        .ex_num2_i        (ex_num2_i),
        .ex_target_i      (ex_target_i),
        .ex_pred_taken_i  (ex_pred_taken_i),
        .ex_pred_target_i (ex_pred_target_i),
        .cmp_op_o         (cmp_op_o),
        .cmp_num1_o       (cmp_num1_o),
        .cmp_num2_o       (cmp_num2_o),
        .cmp_taken_i      (cmp_taken_i),
        .flush_i          (flush_i),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .res_valid_o      (res_valid_o),
        .res_taken_o      (res_taken_o),
        .res_pc_o         (res_pc_o),
        .misalign_o       (misalign_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rdly_cfg = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic        taken;
        logic [31:0] pc;
        logic        flush;
        logic        mis;
        logic [31:0] rpc;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];

    // reference state
    logic [31:0] m_br;
    logic [31:0] m_mis;
    logic [31:0] m_rpc;

    // shared comparator: jumps always taken, otherwise RISC-V branch funcs
    function automatic logic cmp_model(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[4:3] == 2'b10) return 1'b1;
        case (op[2:0])
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) <  $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a <  b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign cmp_taken_i = cmp_model(cmp_op_o, cmp_num1_o, cmp_num2_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [31:0] pc, input logic [4:0] op,
                                       input logic [31:0] n1, input logic [31:0] n2,
                                       input logic [31:0] tgt, input logic pt,
                                       input logic [31:0] ptgt);
        exp_t e;
        logic tk, mp, ma, br;
        logic [31:0] npc;
        br  = (op[4:3] == 2'b01) || (op[4:3] == 2'b10);
        tk  = br ? cmp_model(op, n1, n2) : 1'b0;
        npc = tk ? tgt : pc + 32'd4;
        mp  = (tk != pt) || (tk && tgt != ptgt);
        ma  = tk && (tgt % 4 != 0);
        if (br) m_br = m_br + 1;
        if (!ma && mp) begin
            m_mis = m_mis + 1;
            m_rpc = npc;
        end
        e.taken = tk;
        e.pc    = pc;
        e.flush = !ma && mp;
        e.mis   = ma;
        e.rpc   = m_rpc;
        e.bc    = m_br;
        e.mc    = m_mis;
        return e;
    endfunction

    // called at a negedge, returns at a negedge with ex_valid_i low
    // abort=1 raises flush_i during the EVAL cycle so no result is expected
    task automatic issue(input logic [31:0] pc, input logic [4:0] op,
                         input logic [31:0] n1, input logic [31:0] n2,
                         input logic [31:0] tgt, input logic pt,
                         input logic [31:0] ptgt, input int rdly,
                         input logic abort, output int acc_cyc);
        int guard;
        ex_valid_i       = 1'b1;
        ex_pc_i          = pc;
        ex_cmp_op_i      = op;
        ex_num1_i        = n1;
        ex_num2_i        = n2;
        ex_target_i      = tgt;
        ex_pred_taken_i  = pt;
        ex_pred_target_i = ptgt;
        guard = 0;
        while (!ex_ready_o && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 200) begin
            chk("accept_timeout", 32'd1, 32'd0);
            ex_valid_i = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(posedge clk_i);
        #1;
        acc_cyc    = cyc;
        ex_valid_i = 1'b0;
        rdly_cfg   = rdly;
        if (abort) begin
            flush_i = 1'b1;
            @(negedge clk_i);
            chk("eval_ready_low", {31'd0, ex_ready_o}, 32'd0);
            @(posedge clk_i);
            #1;
            flush_i = 1'b0;
        end else begin
            sb.push_back(ref_model(pc, op, n1, n2, tgt, pt, ptgt));
        end
        @(negedge clk_i);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_n_i) begin
                if (res_valid_o) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_res", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_taken",      {31'd0, res_taken_o},      {31'd0, e.taken});
                        chk("res_pc",         res_pc_o,                  e.pc);
                        chk("flush_o",        {31'd0, flush_o},          {31'd0, e.flush});
                        chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, e.flush});
                        chk("misalign_o",     {31'd0, misalign_o},       {31'd0, e.mis});
                        chk("redirect_pc",    redirect_pc_o,             e.rpc);
                        chk("branch_cnt",     branch_cnt_o,              e.bc);
                        chk("mispred_cnt",    mispred_cnt_o,             e.mc);
                    end
                end else begin
                    chk("stray_pulse", {30'd0, flush_o, misalign_o}, 32'd0);
                end
            end
        end
    end

    // fetch responder with programmable back-pressure
    initial begin
        int hold;
        logic ready_was;
        logic [31:0] hold_pc;
        hold = 0;
        ready_was = 1'b0;
        hold_pc = 32'd0;
        redirect_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (ready_was) begin
                chk("redirect_drop", {31'd0, redirect_valid_o}, 32'd0);
                redirect_ready_i = 1'b0;
                ready_was = 1'b0;
                hold = 0;
            end else if (redirect_valid_o) begin
                if (hold == 0) begin
                    hold_pc = redirect_pc_o;
                end else begin
                    chk("redirect_pc_stable", redirect_pc_o, hold_pc);
                    chk("redirect_ready_low", {31'd0, ex_ready_o}, 32'd0);
                end
                if (hold >= rdly_cfg) begin
                    redirect_ready_i = 1'b1;
                    ready_was = 1'b1;
                end
                hold++;
            end else begin
                hold = 0;
            end
        end
    end

    task automatic wait_redirect();
        int guard;
        guard = 0;
        while (!redirect_valid_o && guard < 20) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 20) chk("redirect_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int a1, a2, guard;
        logic [4:0]  op;
        logic [31:0] n1, n2, tgt, ptgt, pc;
        logic [2:0]  funcs [6];
        funcs[0] = 3'd0; funcs[1] = 3'd1; funcs[2] = 3'd4;
        funcs[3] = 3'd5; funcs[4] = 3'd6; funcs[5] = 3'd7;

        m_br = 0; m_mis = 0; m_rpc = 32'h0;
        rst_n_i = 1'b0;
        flush_i = 1'b0;
        ex_valid_i = 1'b0;
        ex_pc_i = 0; ex_cmp_op_i = 0; ex_num1_i = 0; ex_num2_i = 0;
        ex_target_i = 0; ex_pred_taken_i = 0; ex_pred_target_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready",    {31'd0, ex_ready_o},       32'd1);
        chk("rst_redir_pc", redirect_pc_o,             32'h0);
        chk("rst_res_pc",   res_pc_o,                  32'h0);
        chk("rst_pulses",   {27'd0, flush_o, redirect_valid_o, res_valid_o, res_taken_o, misalign_o}, 32'd0);
        chk("rst_cnts",     branch_cnt_o | mispred_cnt_o, 32'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // taken BEQ predicted not-taken
        issue(32'h40, 5'b01_000, 32'd5, 32'd5, 32'h100, 1'b0, 32'h0, 0, 1'b0, a1);
        repeat (3) @(negedge clk_i);

        // BLTU not taken, then a back-to-back op
        issue(32'h80, 5'b01_110, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0, 32'h0, 0, 1'b0, a1);
        issue(32'h84, 5'b01_000, 32'd1, 32'd2, 32'h400, 1'b0, 32'h0, 0, 1'b0, a2);
        chk("back_to_back", a2 - a1, 32'd2);

        // jump with wrong predicted target and 3 cycles of back-pressure
        issue(32'h1F0, 5'b10_000, 32'd0, 32'd0, 32'h204, 1'b1, 32'h200, 3, 1'b0, a1);

        // non-branch predicted taken, PC wraps
        issue(32'hFFFF_FFFC, 5'b00_000, 32'd3, 32'd3, 32'h500, 1'b1, 32'h500, 0, 1'b0, a1);

        // taken BNE to a misaligned target
        issue(32'h600, 5'b01_001, 32'd1, 32'd2, 32'h102, 1'b0, 32'h0, 0, 1'b0, a1);

        // flush in EVAL
        issue(32'h700, 5'b01_000, 32'd9, 32'd9, 32'h800, 1'b0, 32'h0, 0, 1'b1, a1);
        chk("flushE_ready", {31'd0, ex_ready_o}, 32'd1);
        chk("flushE_cnt",   branch_cnt_o, m_br);

        // flush in IDLE blocks acceptance
        flush_i = 1'b1;
        ex_valid_i = 1'b1;
        #1;
        chk("flushI_ready", {31'd0, ex_ready_o}, 32'd0);
        @(negedge clk_i);
        ex_valid_i = 1'b0;
        flush_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // flush in REDIRECT
        issue(32'h900, 5'b01_000, 32'd1, 32'd1, 32'hA00, 1'b0, 32'h0, 50, 1'b0, a1);
        wait_redirect();
        flush_i = 1'b1;
        @(negedge clk_i);
        chk("flushR_redir", {31'd0, redirect_valid_o}, 32'd0);
        chk("flushR_mcnt",  mispred_cnt_o, m_mis);
        flush_i = 1'b0;
        #1;
        chk("flushR_ready", {31'd0, ex_ready_o}, 32'd1);
        @(negedge clk_i);

        // reset mid-REDIRECT
        issue(32'hB00, 5'b10_000, 32'd0, 32'd0, 32'hC00, 1'b0, 32'h0, 50, 1'b0, a1);
        wait_redirect();
        #3;
        rst_n_i = 1'b0;
        #1;
        chk("rstR_pulses", {27'd0, flush_o, redirect_valid_o, res_valid_o, res_taken_o, misalign_o}, 32'd0);
        chk("rstR_pcs",    redirect_pc_o | res_pc_o, 32'h0);
        chk("rstR_cnts",   branch_cnt_o | mispred_cnt_o, 32'd0);
        chk("rstR_cmp",    {27'd0, cmp_op_o} | cmp_num1_o | cmp_num2_o, 32'd0);
        chk("rstR_ready",  {31'd0, ex_ready_o}, 32'd1);
        m_br = 0; m_mis = 0; m_rpc = 32'h0;
        sb.delete();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        // randomized ops
        for (int i = 0; i < 300; i++) begin
            op   = {2'($urandom_range(0, 3)), funcs[$urandom_range(0, 5)]};
            n1   = $urandom;
            n2   = ($urandom_range(0, 3) == 0) ? n1 : $urandom;
            pc   = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            tgt  = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            ptgt = ($urandom_range(0, 1) == 0) ? tgt : ($urandom & 32'hFFFF_FFFC);
            issue(pc, op, n1, n2, tgt, 1'($urandom_range(0, 1)), ptgt,
                  $urandom_range(0, 3), ($urandom_range(0, 15) == 0), a1);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        chk("sb_drained", sb.size(), 32'd0);
        repeat (6) @(negedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
